divider16bit_seq: RTL

DIVIDER16BIT_SEQ -- requirements
Module: divider16bit_seq

---
 rtl/div_pkg.sv | 12 +
 rtl/divider16bit_seq_if.sv | 27 ++
 rtl/div_step.sv | 21 ++
 rtl/divider16bit_seq.sv | 114 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider16bit_seq_if.sv
// Operand/result handshake bundle for the divider; slave = divider, master = producer/consumer.
interface divider16bit_seq_if import div_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
);

  logic                 in_valid;
  logic                 in_ready;
  logic [2*DIV_W-1:0]   dividend;
  logic [DIV_W-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIV_W-1:0]     quotient;
  logic [DIV_W-1:0]     remainder;
  logic                 div_zero;
  logic                 ovf;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

endinterface

// File: rtl/div_step.sv
// One restoring iteration: compare the shifted partial remainder with the divisor, subtract if it fits.
// Purely combinational; the result always fits in DIV_W bits because the remainder stays below the divisor.
module div_step #(
  parameter int DIV_W = 16
) (
  input  logic [DIV_W:0]   prem_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [DIV_W-1:0] prem_o,
  output logic             qbit_o
);

  logic [DIV_W+1:0] diff;
  logic             unused_diff_msb;

  // The extra top bit is the borrow: clear means prem_i >= divisor.
  assign diff            = {1'b0, prem_i} - {2'b00, divisor_i};
  assign qbit_o          = ~diff[DIV_W+1];
  assign prem_o          = qbit_o ? diff[DIV_W-1:0] : prem_i[DIV_W-1:0];
  assign unused_diff_msb = diff[DIV_W];

endmodule

// File: rtl/divider16bit_seq.sv
// Sequential 2N/N unsigned divider: one quotient bit per cycle, result DIV_W+1 cycles after accept (1 on error).
// Accepts only in IDLE; result held in DONE until out_ready, so in_ready stays low while the consumer stalls.
module divider16bit_seq import div_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  divider16bit_seq_if.slave  io
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   prem_q, prem_d;
  logic [DIV_W-1:0]   lo_q, lo_d;
  logic [DIV_W-1:0]   dsr_q, dsr_d;
  logic [DIV_W-1:0]   quo_q, quo_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;

  logic [DIV_W:0]     step_in;
  logic [DIV_W-1:0]   step_rem;
  logic               step_qbit;

  // Low dividend half feeds the shift MSB-first.
  assign step_in = {prem_q, lo_q[DIV_W-1]};

  div_step #(.DIV_W(DIV_W)) u_step (
    .prem_i    (step_in),
    .divisor_i (dsr_q),
    .prem_o    (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    lo_d    = lo_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (io.divisor == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            quo_d   = '1;
            prem_d  = io.dividend[DIV_W-1:0];
          end else if (io.dividend[2*DIV_W-1:DIV_W] >= io.divisor) begin
            // Quotient would need more than DIV_W bits.
            state_d = DONE;
            ovf_d   = 1'b1;
            quo_d   = '1;
            prem_d  = '0;
          end else begin
            state_d = BUSY;
            prem_d  = io.dividend[2*DIV_W-1:DIV_W];
            lo_d    = io.dividend[DIV_W-1:0];
            dsr_d   = io.divisor;
            quo_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        prem_d = step_rem;
        lo_d   = {lo_q[DIV_W-2:0], 1'b0};
        quo_d  = {quo_q[DIV_W-2:0], step_qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      lo_q    <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      lo_q    <= lo_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.quotient  = quo_q;
  assign io.remainder = prem_q;
  assign io.div_zero  = dz_q;
  assign io.ovf       = ovf_q;

endmodule
